// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: bursts a program image from DDR into a local
// 64-bit RAM, then serves one-cycle-latency reads with empty/not-empty status.
module instr_mem_loader #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int DDR_AW    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [DDR_AW-1:0] ddr_base_addr,
    input  logic [ADDR_W:0]   instr_num,
    output logic              ddr_rd_req,
    output logic [DDR_AW-1:0] ddr_rd_addr,
    output logic [8:0]        ddr_rd_len,
    input  logic              ddr_rd_ack,
    input  logic              ddr_rd_valid,
    input  logic [63:0]       ddr_rd_data,
    input  logic              ddr_rd_last,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_rd_enable,
    output logic [63:0]       i_mem_din,
    output logic              i_mem_empty,
    output logic              load_busy,
    output logic              load_done,
    output logic              rd_oob
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_READY} state_e;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        return (n > DEPTH_W) ? DEPTH_W : n;
    endfunction

    function automatic logic [8:0] burst_len(input logic [ADDR_W:0] n);
        int unsigned v;
        v = 32'(n);
        return (v > 32'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(v);
    endfunction

    function automatic logic [DDR_AW-1:0] word_to_byte(input logic [ADDR_W-1:0] w);
        return DDR_AW'({w, 3'b000});
    endfunction

    state_e            state_q;
    logic [DDR_AW-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              req_q;
    logic [DDR_AW-1:0] addr_q;
    logic [8:0]        len_q;
    logic              empty_q;
    logic              busy_q;
    logic              done_q;
    logic [63:0]       din_q;
    logic              oob_q;
    logic [63:0]       mem [DEPTH];

    logic              beat_wr;
    logic [ADDR_W:0]   remaining_d;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic              rd_in_range;
    logic              rd_last_word;

    // Surplus beats (remaining already zero) neither write nor move the pointer.
    assign beat_wr      = (state_q == S_DATA) && ddr_rd_valid && (remaining_q != '0);
    assign remaining_d  = beat_wr ? remaining_q - CNT_ONE : remaining_q;
    assign wr_ptr_d     = beat_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_in_range  = {1'b0, i_mem_addr} < count_q;
    assign rd_last_word = i_mem_rd_enable && ({1'b0, i_mem_addr} == count_q - CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            empty_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            case (state_q)
                S_IDLE: begin
                    if (fetch_req && (instr_num != '0)) begin
                        base_q      <= ddr_base_addr;
                        count_q     <= clamp_count(instr_num);
                        remaining_q <= clamp_count(instr_num);
                        wr_ptr_q    <= '0;
                        req_q       <= 1'b1;
                        addr_q      <= ddr_base_addr;
                        len_q       <= burst_len(clamp_count(instr_num));
                        busy_q      <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ddr_rd_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ddr_rd_valid && ddr_rd_last) begin
                        if (remaining_d == '0) begin
                            done_q  <= 1'b1;
                            empty_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_READY;
                        end else begin
                            // Next burst resumes where this one stopped writing.
                            req_q   <= 1'b1;
                            addr_q  <= base_q + word_to_byte(wr_ptr_d);
                            len_q   <= burst_len(remaining_d);
                            state_q <= S_REQ;
                        end
                    end
                end
                S_READY: begin
                    if (rd_last_word) begin
                        empty_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            mem[wr_ptr_q] <= ddr_rd_data;
        end
    end

    // Read-first: the nonblocking RAM write lands after this read samples mem.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= '0;
            oob_q <= 1'b0;
        end else if (i_mem_rd_enable) begin
            if (rd_in_range) begin
                din_q <= mem[i_mem_addr];
            end else begin
                din_q <= '0;
                oob_q <= 1'b1;
            end
        end
    end

    assign ddr_rd_req  = req_q;
    assign ddr_rd_addr = addr_q;
    assign ddr_rd_len  = len_q;
    assign i_mem_din   = din_q;
    assign i_mem_empty = empty_q;
    assign load_busy   = busy_q;
    assign load_done   = done_q;
    assign rd_oob      = oob_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: DDR responder plus an image/array model of what
// the RAM must hold, the burst sequence it must request, and read status.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] ddr_base_addr = '0;
    logic [10:0] instr_num = '0;
    logic        ddr_rd_req;
    logic [31:0] ddr_rd_addr;
    logic [8:0]  ddr_rd_len;
    logic        ddr_rd_ack = 1'b0;
    logic        ddr_rd_valid = 1'b0;
    logic [63:0] ddr_rd_data = '0;
    logic        ddr_rd_last = 1'b0;
    logic [9:0]  i_mem_addr = '0;
    logic        i_mem_rd_enable = 1'b0;
    logic [63:0] i_mem_din;
    logic        i_mem_empty;
    logic        load_busy;
    logic        load_done;
    logic        rd_oob;

    int passed = 0;
    int total  = 0;

    logic [63:0] img [0:1023];
    int          cur_cnt = 0;
    bit          exp_oob = 1'b0;
    bit          exhausted = 1'b0;

    instr_mem_loader #(.DEPTH(1024), .ADDR_W(10), .DDR_AW(32), .BURST_LEN(16)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .ddr_base_addr(ddr_base_addr),
        .instr_num(instr_num), .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
        .ddr_rd_len(ddr_rd_len), .ddr_rd_ack(ddr_rd_ack), .ddr_rd_valid(ddr_rd_valid),
        .ddr_rd_data(ddr_rd_data), .ddr_rd_last(ddr_rd_last), .i_mem_addr(i_mem_addr),
        .i_mem_rd_enable(i_mem_rd_enable), .i_mem_din(i_mem_din), .i_mem_empty(i_mem_empty),
        .load_busy(load_busy), .load_done(load_done), .rd_oob(rd_oob)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = {$urandom, $urandom};
    endtask

    task automatic start_load(input logic [31:0] base, input int n);
        ddr_base_addr = base;
        instr_num     = 11'(n);
        fetch_req     = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        cur_cnt   = (n > 1024) ? 1024 : n;
        exhausted = 1'b0;
        total++;
        if (ddr_rd_req !== 1'b1 || load_busy !== 1'b1)
            $display("FAIL load_start: req=%b busy=%b expected req=1 busy=1", ddr_rd_req, load_busy);
        else passed++;
    endtask

    // Acts as the DDR controller until the whole image has been delivered.
    task automatic serve_load(input logic [31:0] base, input int ack_wait, input int extra, input int max_gap);
        int off = 0;
        int len;
        int nb;
        int w;
        bit stable;
        logic [31:0] ea;
        while (off < cur_cnt) begin
            len = (cur_cnt - off > 16) ? 16 : cur_cnt - off;
            ea  = base + 32'(off * 8);
            w = 0;
            while (ddr_rd_req !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            total++;
            if (ddr_rd_req !== 1'b1 || ddr_rd_addr !== ea || ddr_rd_len !== 9'(len)) begin
                $display("FAIL burst_req: req=%b addr=%h len=%0d expected req=1 addr=%h len=%0d",
                         ddr_rd_req, ddr_rd_addr, ddr_rd_len, ea, len);
                return;
            end else passed++;
            stable = 1'b1;
            repeat (ack_wait) begin
                @(negedge clk);
                if (ddr_rd_req !== 1'b1 || ddr_rd_addr !== ea || ddr_rd_len !== 9'(len)) stable = 1'b0;
            end
            if (ack_wait > 0) begin
                total++;
                if (!stable)
                    $display("FAIL stall_stable: req=%b addr=%h len=%0d expected req=1 addr=%h len=%0d",
                             ddr_rd_req, ddr_rd_addr, ddr_rd_len, ea, len);
                else passed++;
            end
            ddr_rd_ack = 1'b1;
            @(negedge clk);
            ddr_rd_ack = 1'b0;
            total++;
            if (ddr_rd_req !== 1'b0) $display("FAIL ack_drop: req=%b expected 0", ddr_rd_req);
            else passed++;
            nb = len + ((off == 0) ? extra : 0);
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(max_gap, 0)) @(negedge clk);
                ddr_rd_valid = 1'b1;
                ddr_rd_data  = (i < len) ? img[off + i] : {$urandom, $urandom};
                ddr_rd_last  = (i == nb - 1);
                @(negedge clk);
                ddr_rd_valid = 1'b0;
                ddr_rd_last  = 1'b0;
            end
            off += len;
            if (off >= cur_cnt) begin
                total++;
                if (load_done !== 1'b1 || i_mem_empty !== 1'b0 || load_busy !== 1'b0)
                    $display("FAIL done: done=%b empty=%b busy=%b expected 1 0 0", load_done, i_mem_empty, load_busy);
                else passed++;
                @(negedge clk);
                total++;
                if (load_done !== 1'b0 || ddr_rd_req !== 1'b0)
                    $display("FAIL done_pulse: done=%b req=%b expected 0 0", load_done, ddr_rd_req);
                else passed++;
            end else begin
                total++;
                if (ddr_rd_req !== 1'b1 || load_done !== 1'b0)
                    $display("FAIL next_req: req=%b done=%b expected 1 0", ddr_rd_req, load_done);
                else passed++;
            end
        end
    endtask

    task automatic read_chk(input int a);
        logic [63:0] e;
        i_mem_addr      = 10'(a);
        i_mem_rd_enable = 1'b1;
        @(negedge clk);
        i_mem_rd_enable = 1'b0;
        e = (a < cur_cnt) ? img[a] : 64'h0;
        if (a >= cur_cnt) exp_oob = 1'b1;
        if (a == cur_cnt - 1) exhausted = 1'b1;
        total++;
        if (i_mem_din !== e || rd_oob !== exp_oob || i_mem_empty !== exhausted)
            $display("FAIL read[%0d]: din=%h oob=%b empty=%b expected din=%h oob=%b empty=%b",
                     a, i_mem_din, rd_oob, i_mem_empty, e, exp_oob, exhausted);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ddr_rd_req !== 1'b0 || ddr_rd_addr !== 32'h0 || ddr_rd_len !== 9'h0 || i_mem_din !== 64'h0 ||
            i_mem_empty !== 1'b1 || load_busy !== 1'b0 || load_done !== 1'b0 || rd_oob !== 1'b0)
            $display("FAIL reset: req=%b addr=%h len=%0d din=%h empty=%b busy=%b done=%b oob=%b expected all idle",
                     ddr_rd_req, ddr_rd_addr, ddr_rd_len, i_mem_din, i_mem_empty, load_busy, load_done, rd_oob);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        logic [63:0] held;
        for (int i = 0; i < 16; i++) img[i] = 64'(i);
        start_load(32'h1000, 16);
        serve_load(32'h1000, 0, 0, 0);
        for (int i = 0; i < 16; i++) read_chk(i);
        held = i_mem_din;
        i_mem_addr = 10'd2;
        @(negedge clk);
        total++;
        if (i_mem_din !== held) $display("FAIL din_hold: din=%h expected %h", i_mem_din, held);
        else passed++;
    endtask

    task automatic test_multi_burst();
        fill_random(40);
        start_load(32'h1000, 40);
        serve_load(32'h1000, 0, 0, 0);
        repeat (5) read_chk($urandom_range(38, 0));
        read_chk(39);
    endtask

    task automatic test_exhaust_reload();
        fill_random(4);
        start_load(32'h2000, 4);
        serve_load(32'h2000, 0, 0, 0);
        for (int i = 0; i < 3; i++) read_chk(i);
        ddr_base_addr   = 32'h3000;
        instr_num       = 11'd8;
        fetch_req       = 1'b1;
        i_mem_addr      = 10'd3;
        i_mem_rd_enable = 1'b1;
        @(negedge clk);
        i_mem_rd_enable = 1'b0;
        total++;
        if (i_mem_empty !== 1'b1 || ddr_rd_req !== 1'b0 || i_mem_din !== img[3])
            $display("FAIL exhaust: empty=%b req=%b din=%h expected 1 0 %h", i_mem_empty, ddr_rd_req, i_mem_din, img[3]);
        else passed++;
        @(negedge clk);
        fetch_req = 1'b0;
        total++;
        if (ddr_rd_req !== 1'b1 || ddr_rd_addr !== 32'h3000 || ddr_rd_len !== 9'd8)
            $display("FAIL reload: req=%b addr=%h len=%0d expected 1 00003000 8", ddr_rd_req, ddr_rd_addr, ddr_rd_len);
        else passed++;
        cur_cnt   = 8;
        exhausted = 1'b0;
        fill_random(8);
        serve_load(32'h3000, 0, 0, 2);
        read_chk(6);
        read_chk(7);
    endtask

    task automatic test_oob();
        fill_random(4);
        start_load(32'h4000, 4);
        serve_load(32'h4000, 0, 0, 0);
        read_chk(5);
        read_chk(1);
        read_chk(3);
    endtask

    task automatic test_surplus();
        fill_random(16);
        start_load(32'h5000, 16);
        serve_load(32'h5000, 0, 4, 0);
        for (int i = 0; i < 16; i++) read_chk(i);
    endtask

    task automatic test_stall();
        fill_random(24);
        start_load(32'h6000, 24);
        serve_load(32'h6000, 10, 0, 1);
        read_chk(0);
        read_chk(23);
    endtask

    task automatic test_reset_mid();
        start_load(32'h7000, 40);
        ddr_rd_ack = 1'b1;
        @(negedge clk);
        ddr_rd_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        exp_oob = 1'b0;
        total++;
        if (ddr_rd_req !== 1'b0 || ddr_rd_addr !== 32'h0 || ddr_rd_len !== 9'h0 || i_mem_din !== 64'h0 ||
            i_mem_empty !== 1'b1 || load_busy !== 1'b0 || load_done !== 1'b0 || rd_oob !== 1'b0)
            $display("FAIL async_reset: req=%b addr=%h len=%0d din=%h empty=%b busy=%b done=%b oob=%b expected all idle",
                     ddr_rd_req, ddr_rd_addr, ddr_rd_len, i_mem_din, i_mem_empty, load_busy, load_done, rd_oob);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ddr_rd_last = (i == 2);
            @(negedge clk);
        end
        ddr_rd_valid = 1'b0;
        ddr_rd_last  = 1'b0;
        total++;
        if (i_mem_empty !== 1'b1 || load_busy !== 1'b0 || load_done !== 1'b0 || ddr_rd_req !== 1'b0)
            $display("FAIL post_reset_beats: empty=%b busy=%b done=%b req=%b expected 1 0 0 0",
                     i_mem_empty, load_busy, load_done, ddr_rd_req);
        else passed++;
    endtask

    task automatic test_clamp_zero();
        ddr_base_addr = 32'h8000;
        instr_num     = 11'd0;
        fetch_req     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (ddr_rd_req !== 1'b0 || load_busy !== 1'b0 || i_mem_empty !== 1'b1)
                $display("FAIL zero_num: req=%b busy=%b empty=%b expected 0 0 1", ddr_rd_req, load_busy, i_mem_empty);
            else passed++;
        end
        fetch_req = 1'b0;
        fill_random(1024);
        start_load(32'h8000, 1100);
        serve_load(32'h8000, 0, 0, 0);
        read_chk(0);
        read_chk(512);
        read_chk($urandom_range(1022, 1));
        read_chk(1023);
    endtask

    task automatic test_random();
        logic [31:0] base;
        int n;
        for (int it = 0; it < 6; it++) begin
            base = (it == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFF8);
            n    = $urandom_range(100, 1);
            fill_random(n);
            start_load(base, n);
            serve_load(base, $urandom_range(3, 0), 0, 2);
            repeat (6) read_chk($urandom_range(n + 5, 0));
            if (!exhausted) read_chk(n - 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_exhaust_reload();
        test_oob();
        test_surplus();
        test_stall();
        test_reset_mid();
        test_clamp_zero();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction-memory loader and server for the accelerator. When the top-level control FSM requests instructions, this block bursts a program image from DDR into a local 64-bit instruction RAM. It then serves the FSM's address/read-enable requests with one-cycle read latency and reports empty/not-empty status back to it. It is the responder side of the `fetch_instruction_from_ddr` / `i_mem_empty` / `i_mem_addr` / `i_mem_rd_enable` / `i_mem_din` interface.

## Interface
- `DEPTH`, 1024: instruction RAM depth in 64-bit words; power of two.
- `ADDR_W`, 10: log2(DEPTH).
- `DDR_AW`, 32: DDR byte-address width.
- `BURST_LEN`, 16: maximum beats per DDR read burst; 1..256.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: level request to load an image; connects to `fetch_instruction_from_ddr`.
- `ddr_base_addr` in DDR_AW: byte address of the image; sampled on load start; 8-byte aligned.
- `instr_num` in ADDR_W+1: number of words to load; sampled on load start.
- `ddr_rd_req` out 1: burst request.
- `ddr_rd_addr` out DDR_AW: burst start byte address.
- `ddr_rd_len` out 9: beats in the burst, 1..BURST_LEN.
- `ddr_rd_ack` in 1: request accepted.
- `ddr_rd_valid` in 1: read data beat valid.
- `ddr_rd_data` in 64: read data beat.
- `ddr_rd_last` in 1: final beat of the burst.
- `i_mem_addr` in ADDR_W: read address.
- `i_mem_rd_enable` in 1: read strobe.
- `i_mem_din` out 64: read data; the name is kept to match the consumer.
- `i_mem_empty` out 1: no readable image.
- `load_busy` out 1: high in REQ or DATA.
- `load_done` out 1: one-cycle pulse when the image is complete.
- `rd_oob` out 1: sticky flag, set by a read at address ≥ loaded count.

## Operation
- **States:** IDLE, REQ, DATA, READY. Encoding is free.
- **IDLE**
  - `i_mem_empty`=1.
  - `fetch_req`=1 with a legal `instr_num` latches `ddr_base_addr` and `min(instr_num, DEPTH)` into `remaining` and `count`, clears `wr_ptr`, and moves to REQ.
  - `instr_num`=0 is ignored; the block stays in IDLE.
- **REQ**
  - `ddr_rd_req`=1, `ddr_rd_addr`=base + 8·`wr_ptr`, `ddr_rd_len`=min(BURST_LEN, `remaining`).
  - Address and length are held stable until `ddr_rd_ack`. On ack: `ddr_rd_req`=0 and the FSM moves to DATA.
- **DATA**
  - Each `ddr_rd_valid` beat with `remaining`>0 writes `mem[wr_ptr]`, then increments `wr_ptr` and decrements `remaining`.
  - Beats arriving when `remaining`=0 are dropped.
  - On a beat with `ddr_rd_last`: if `remaining` after that beat is 0, pulse `load_done` and move to READY; otherwise return to REQ.
- **READY**
  - `i_mem_empty`=0.
  - A read with `i_mem_addr` = `count`−1 exhausts the image: the FSM moves to IDLE and `i_mem_empty` goes to 1.
- **Reads**
  - `i_mem_rd_enable`=1 registers `mem[i_mem_addr]` into `i_mem_din`. Reads are served in every state.
  - A read at address ≥ `count` returns 64'h0 and sets `rd_oob`.
  - `i_mem_din` holds its value when `rd_enable`=0.
- `fetch_req` is ignored outside IDLE.
- `ddr_rd_valid` outside DATA is ignored.
- Write and read to the same address in the same cycle returns the old data (read-first).
- `ddr_rd_addr` arithmetic is modulo 2^DDR_AW.
- `wr_ptr` never exceeds DEPTH−1, because `count` is clamped to DEPTH.

## Timing
- **Reset values:** `ddr_rd_req`=0, `ddr_rd_addr`=0, `ddr_rd_len`=0, `i_mem_din`=0, `i_mem_empty`=1, `load_busy`=0, `load_done`=0, `rd_oob`=0, state=IDLE. RAM contents are not reset.
- **Reset mid-load:** the burst is abandoned and the block returns to IDLE. Subsequent DDR beats are ignored while in IDLE.
- All outputs are registered.
- **Load start:** `fetch_req` sampled high at edge N gives `ddr_rd_req`=1 and `load_busy`=1 from edge N+1.
- **Ack:** `ddr_rd_ack` sampled at edge M drops `ddr_rd_req` at M+1. The next burst's `ddr_rd_req` rises one cycle after the `last` beat is sampled.
- **Completion:** the final beat sampled at edge K gives `load_done`=1 for the cycle K+1..K+2, `i_mem_empty`=0 and `load_busy`=0 from K+1.
- **Read latency:** `i_mem_rd_enable` sampled at edge R gives data on `i_mem_din` from R+1.
- **Exhaustion:** the read of the last address at edge R sets `i_mem_empty`=1 from R+1. `fetch_req` is honored from edge R+1 onward.
- DATA accepts one beat per cycle; back-to-back beats have no bubbles.

## Test plan
- **Single burst:** base=0x1000, `instr_num`=16, immediate ack, 16 back-to-back beats carrying data=index → exactly one request with addr=0x1000 and len=16. `load_done` pulses once, `i_mem_empty` falls; reads at 0..15 return 0..15 one cycle later.
- **Multi-burst:** `instr_num`=40 → requests (0x1000, 16), (0x1080, 16), (0x1100, 8). `load_done` pulses only after the 40th beat.
- **Exhaustion and reload:** after a 4-word load, read addresses 0,1,2,3 → `i_mem_empty`=1 on the cycle after the address-3 read. With `fetch_req` held high, the next `ddr_rd_req` rises one cycle later.
- **Out-of-bounds and surplus beats:** read address 5 after a 4-word load → `i_mem_din`=0 and `rd_oob`=1, sticky. Separately, 20 beats sent on a len=16 burst with `last` on beat 20 → only 16 words are written.
- **Stalled ack and reset:** hold `ddr_rd_ack`=0 for 10 cycles → `ddr_rd_req`, `ddr_rd_addr` and `ddr_rd_len` stay stable throughout. Assert `rst`=0 mid-DATA → all outputs return to reset values immediately, without waiting for a clock edge.
- **Clamp and zero:** `instr_num`=0 → no request and the block stays IDLE. `instr_num`=1100 → 1024 words are loaded and `load_done` pulses.
